morse_pulse_classifier: RTL and testbench
=========================================

// Module: morse_pulse_classifier
// PURPOSE
//   Front-end sequencer for translate_morse.
//   - Times a debounced, synchronised Morse key against a tick strobe.
//   - Drives translate_morse.pulse_event with one-cycle codes:
//     1 = dit, 2 = dash, 3 = inter-letter space, 4 = inter-word space, 0 = nothing.
//   - Sits between key_debounce and translate_morse; decides when each symbol and each gap is complete.
// PARAMETERS
//   CNT_W       10   width of the tick counter; all thresholds < 2**CNT_W
//   MIN_PRESS   10   presses shorter than this many ticks are glitches and are discarded
//   DASH_MIN    200  press length in ticks at or above which the symbol is a dash
//   LETTER_GAP  250  key-low ticks after a symbol that close the letter
//   WORD_GAP    600  key-low ticks after a symbol that close the word; must be > LETTER_GAP
// PORTS
//   clk          in   1  system clock
//   rst          in   1  asynchronous, active-high reset
//   tick         in   1  time-base strobe, 1 clk wide (1 ms in the top level)
//   enable       in   1  0 = hold in IDLE, emit nothing
//   key          in   1  debounced key, 1 = pressed
//   pulse_event  out  3  event code to translate_morse; one clk wide, 0 otherwise
//   sym_count    out  3  number of symbols accepted in the current letter, saturates at 7
//   busy         out  1  1 in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, pulse_event=0, sym_count=0, busy=0.
//   All outputs are registered.
//   The tick counter cnt increments only on clk edges with tick=1, saturates at 2**CNT_W-1,
//   and clears on every state entry.
//   Event timing: an event decided at edge N is visible in cycle N+1 for exactly one clk.
//   States:
//   - IDLE
//     - key=1 and enable=1 -> PRESS.
//   - PRESS (counting key-high ticks)
//     - key=0 with cnt<MIN_PRESS: glitch, no event. Go to GAP if sym_count>0 or a word is
//       open, else IDLE.
//     - key=0 with MIN_PRESS<=cnt<DASH_MIN: emit 1, sym_count+1, go to GAP.
//     - key=0 with cnt>=DASH_MIN: emit 2, sym_count+1, go to GAP.
//     - A stuck key saturates cnt; release then classifies as a dash.
//   - GAP (counting key-low ticks)
//     - key=1 -> PRESS. The key takes priority over a threshold reached on the same edge,
//       so no gap event is emitted on that edge.
//     - cnt reaches LETTER_GAP: emit 3 once, sym_count=0, stay in GAP.
//     - cnt reaches WORD_GAP: emit 4 once, go to IDLE; the word is closed.
//     - Events 3 and 4 are each emitted at most once per gap and only after at least
//       one accepted symbol.
//   - Word open flag: set on the first accepted symbol, cleared when 4 is emitted.
//     A glitch press in a gap re-enters GAP with cnt=0, so the gap restarts.
//   - enable=0 in any state: go to IDLE at the next edge, emit nothing, sym_count=0,
//     word closed. Pending symbols are dropped without emitting 3.
//   - Async rst mid-operation: immediate return to reset values. No event is produced by
//     the release that follows.
//   - pulse_event is never nonzero on two consecutive cycles.
// TESTING
//   Bench parameters: CNT_W=6, MIN_PRESS=2, DASH_MIN=6, LETTER_GAP=8, WORD_GAP=20,
//   tick=1 every clk, enable=1.
//   1. rst=1 for 2 clk with key=1 -> pulse_event=0, sym_count=0, busy=0; release -> no event.
//   2. key high 3 ticks, release -> single pulse_event=1, sym_count=1.
//      Then key high 7 ticks -> single 2, sym_count=2.
//   3. After one dit, key low 25 ticks -> single 3 at gap tick 8 with sym_count->0,
//      single 4 at tick 20, busy->0, then silence.
//   4. Four 3-tick presses separated by 3-tick gaps, then idle -> events 1,1,1,1,3,4
//      (letter H), sym_count 1..4 then 0.
//   5. 1-tick glitch press in IDLE and inside a gap -> no event; sym_count unchanged;
//      gap timing restarts.
//   6. rst pulse mid-PRESS, or enable=0 mid-letter -> outputs return to 0 immediately or
//      at the next edge; no 3 or 4 emitted for the dropped letter.

Source files
------------

// File: rtl/morse_pulse_classifier.sv
// Times a debounced Morse key against a tick strobe and emits one-cycle dit/dash/letter/word codes.
// Latency: an event decided at a clk edge is visible for the following cycle; no backpressure, events are fire-and-forget.
module morse_pulse_classifier #(
  parameter int CNT_W      = 10,
  parameter int MIN_PRESS  = 10,
  parameter int DASH_MIN   = 200,
  parameter int LETTER_GAP = 250,
  parameter int WORD_GAP   = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       key,
  output logic [2:0] pulse_event,
  output logic [2:0] sym_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] LETTER_C = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_GAP);

  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_DIT    = 3'd1;
  localparam logic [2:0] EV_DASH   = 3'd2;
  localparam logic [2:0] EV_LETTER = 3'd3;
  localparam logic [2:0] EV_WORD   = 3'd4;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             cnt_clr;
  logic             word_open, word_open_nxt;
  logic [2:0]       event_nxt, sym_nxt, sym_inc;
  logic             gap_letter, gap_word;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign sym_inc = (sym_count == 3'd7) ? 3'd7 : sym_count + 3'd1;

  // A gap threshold fires only on the tick that moves cnt onto it, so each fires once per gap.
  assign gap_letter = tick && (cnt != CNT_MAX) && (cnt_inc == LETTER_C);
  assign gap_word   = tick && (cnt != CNT_MAX) && (cnt_inc == WORD_C);

  always_comb begin
    state_nxt     = state;
    event_nxt     = EV_NONE;
    sym_nxt       = sym_count;
    word_open_nxt = word_open;
    cnt_clr       = 1'b0;

    if (!enable) begin
      state_nxt     = IDLE;
      sym_nxt       = 3'd0;
      word_open_nxt = 1'b0;
      cnt_clr       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clr = 1'b1;
          if (key) state_nxt = PRESS;
        end
        PRESS: begin
          if (!key) begin
            cnt_clr = 1'b1;
            if (cnt < MIN_C) begin
              state_nxt = (sym_count != 3'd0 || word_open) ? GAP : IDLE;
            end else begin
              event_nxt     = (cnt >= DASH_C) ? EV_DASH : EV_DIT;
              sym_nxt       = sym_inc;
              word_open_nxt = 1'b1;
              state_nxt     = GAP;
            end
          end
        end
        GAP: begin
          if (key) begin
            state_nxt = PRESS;
            cnt_clr   = 1'b1;
          end else if (gap_word && word_open) begin
            event_nxt     = EV_WORD;
            sym_nxt       = 3'd0;
            word_open_nxt = 1'b0;
            state_nxt     = IDLE;
            cnt_clr       = 1'b1;
          end else if (gap_letter && sym_count != 3'd0) begin
            event_nxt = EV_LETTER;
            sym_nxt   = 3'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      word_open   <= 1'b0;
      sym_count   <= 3'd0;
      pulse_event <= EV_NONE;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_clr ? '0 : (tick ? cnt_inc : cnt);
      word_open   <= word_open_nxt;
      sym_count   <= sym_nxt;
      pulse_event <= event_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_morse_pulse_classifier.sv
// Bench for morse_pulse_classifier: directed Morse scenarios plus randomized key traffic against a duration-based model.
module tb_morse_pulse_classifier;

  localparam int CNT_W      = 6;
  localparam int MIN_PRESS  = 2;
  localparam int DASH_MIN   = 6;
  localparam int LETTER_GAP = 8;
  localparam int WORD_GAP   = 20;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b1;
  logic       enable = 1'b1;
  logic       key = 1'b0;
  logic [2:0] pulse_event;
  logic [2:0] sym_count;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tick_rand = 1'b0;

  always #5 clk = ~clk;

  morse_pulse_classifier #(
    .CNT_W(CNT_W), .MIN_PRESS(MIN_PRESS), .DASH_MIN(DASH_MIN),
    .LETTER_GAP(LETTER_GAP), .WORD_GAP(WORD_GAP)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .key(key),
    .pulse_event(pulse_event), .sym_count(sym_count), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a press or a gap is just a running tick length; symbols and letter/word closure follow from those lengths.
  bit m_press, m_gap, m_word;
  int m_len, m_syms, m_ev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_press = 0; m_gap = 0; m_word = 0; m_len = 0; m_syms = 0; m_ev = 0;
    end else begin
      m_ev = 0;
      if (!enable) begin
        m_press = 0; m_gap = 0; m_word = 0; m_syms = 0;
      end else if (m_press) begin
        if (key) begin
          if (tick && m_len < CNT_MAX) m_len++;
        end else begin
          m_press = 0;
          if (m_len >= MIN_PRESS) begin
            m_ev   = (m_len >= DASH_MIN) ? 2 : 1;
            m_syms = (m_syms < 7) ? m_syms + 1 : 7;
            m_word = 1;
            m_gap  = 1;
          end else begin
            m_gap = (m_syms > 0) || m_word;
          end
          m_len = 0;
        end
      end else if (m_gap) begin
        if (key) begin
          m_gap = 0; m_press = 1; m_len = 0;
        end else if (tick && m_len < CNT_MAX) begin
          m_len++;
          if (m_len == WORD_GAP && m_word) begin
            m_ev = 4; m_gap = 0; m_word = 0; m_syms = 0;
          end else if (m_len == LETTER_GAP && m_syms > 0) begin
            m_ev = 3; m_syms = 0;
          end
        end
      end else if (key) begin
        m_press = 1; m_len = 0;
      end
    end
  end

  int d_ev[$], d_sym[$], d_t[$], m_evq[$];
  int prev_ev = 0;

  always @(negedge clk) begin
    cyc++;
    check("pulse_event", int'(pulse_event), m_ev);
    check("sym_count", int'(sym_count), m_syms);
    check("busy", int'(busy), int'(m_press || m_gap));
    if (prev_ev != 0) check("event_spacing", int'(pulse_event), 0);
    if (pulse_event != 3'd0) begin
      d_ev.push_back(int'(pulse_event));
      d_sym.push_back(int'(sym_count));
      d_t.push_back(cyc);
    end
    if (m_ev != 0) m_evq.push_back(m_ev);
    prev_ev = int'(pulse_event);
  end

  task automatic hold(input logic k, input int n);
    key = k;
    repeat (n) begin
      tick = tick_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_log();
    d_ev.delete(); d_sym.delete(); d_t.delete(); m_evq.delete();
  endtask

  int exp_ev[$], exp_sy[$];

  task automatic check_seq(input string name);
    check({name, "_dut_count"}, d_ev.size(), exp_ev.size());
    check({name, "_model_count"}, m_evq.size(), exp_ev.size());
    for (int i = 0; i < d_ev.size() && i < exp_ev.size(); i++) begin
      check($sformatf("%s_ev%0d", name, i), d_ev[i], exp_ev[i]);
      check($sformatf("%s_sym%0d", name, i), d_sym[i], exp_sy[i]);
    end
    for (int i = 0; i < m_evq.size() && i < exp_ev.size(); i++)
      check($sformatf("%s_model_ev%0d", name, i), m_evq[i], exp_ev[i]);
  endtask

  initial begin
    #1;
    rst = 1'b1;
    key = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_event", int'(pulse_event), 0);
    check("rst_sym", int'(sym_count), 0);
    check("rst_busy", int'(busy), 0);

    // Reset release with the key still down, then a 1-tick press: nothing.
    clr_log();
    rst = 1'b0;
    hold(1, 1);
    hold(0, 5);
    exp_ev = {}; exp_sy = {};
    check_seq("t1");

    // Dit then dash, then the gap closes letter and word.
    clr_log();
    hold(1, 3);
    hold(0, 2);
    check("t2_sym_after_dit", int'(sym_count), 1);
    hold(1, 7);
    hold(0, 25);
    exp_ev = '{1, 2, 3, 4}; exp_sy = '{1, 2, 0, 0};
    check_seq("t2");

    // Single dit: letter close 8 ticks and word close 20 ticks after release.
    clr_log();
    hold(1, 3);
    hold(0, 25);
    exp_ev = '{1, 3, 4}; exp_sy = '{1, 0, 0};
    check_seq("t3");
    if (d_t.size() >= 3) begin
      check("t3_letter_delay", d_t[1] - d_t[0], 8);
      check("t3_word_delay", d_t[2] - d_t[0], 20);
    end
    check("t3_busy_end", int'(busy), 0);
    hold(0, 10);
    check("t3_silence", d_ev.size(), 3);

    // Letter H.
    clr_log();
    repeat (4) begin
      hold(1, 3);
      hold(0, 3);
    end
    hold(0, 25);
    exp_ev = '{1, 1, 1, 1, 3, 4}; exp_sy = '{1, 2, 3, 4, 0, 0};
    check_seq("t4");

    // Glitch in IDLE, then a glitch inside a gap restarts the gap timing.
    clr_log();
    hold(1, 1);
    hold(0, 5);
    check("t5_idle_glitch_busy", int'(busy), 0);
    hold(1, 3);
    hold(0, 5);
    hold(1, 1);
    check("t5_sym_kept", int'(sym_count), 1);
    hold(0, 30);
    exp_ev = '{1, 3, 4}; exp_sy = '{1, 0, 0};
    check_seq("t5");
    if (d_t.size() >= 3) begin
      check("t5_letter_delay", d_t[1] - d_t[0], 14);
      check("t5_word_delay", d_t[2] - d_t[0], 26);
    end

    // Async reset mid-press drops the letter at once.
    clr_log();
    hold(1, 3);
    hold(0, 3);
    hold(1, 4);
    rst = 1'b1;
    #1;
    check("t6_rst_sym", int'(sym_count), 0);
    check("t6_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold(0, 30);
    exp_ev = '{1}; exp_sy = '{1};
    check_seq("t6a");

    // enable=0 mid-letter drops it at the next edge.
    clr_log();
    hold(1, 3);
    hold(0, 3);
    hold(1, 3);
    hold(0, 2);
    enable = 1'b0;
    hold(0, 1);
    check("t6_en_sym", int'(sym_count), 0);
    check("t6_en_busy", int'(busy), 0);
    hold(0, 2);
    enable = 1'b1;
    hold(0, 30);
    exp_ev = '{1, 1}; exp_sy = '{1, 2};
    check_seq("t6b");

    // Randomized traffic, alternating full-rate and sparse tick.
    for (int seg = 0; seg < 1200; seg++) begin
      int r;
      tick_rand = ((seg / 200) % 2) == 1;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        hold(1'($urandom_range(0, 1)), 1);
        rst = 1'b0;
      end else if (r < 5) begin
        enable = 1'b0;
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        enable = 1'b1;
      end else if (seg % 2 == 0) begin
        case ($urandom_range(0, 3))
          0: hold(1, $urandom_range(1, 3));
          1: hold(1, $urandom_range(3, 6));
          2: hold(1, $urandom_range(6, 12));
          default: hold(1, $urandom_range(60, 70));
        endcase
      end else begin
        hold(0, $urandom_range(1, 30));
      end
    end
    tick_rand = 1'b0;
    hold(0, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
